// File: rtl/ffas.sv
// ffas: digit-serial modular adder/subtractor over a fixed prime field.
// Operands are consumed DIGIT bits per cycle, LSB slice first, with two
// carry chains running side by side so the final reduction is a mux.
// Optional feature macro: FFAS_SUB_EN enables op=1 (subtract); without it
// op is ignored and the block always adds with identical latency.
module ffas #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DIGIT = 64,
  parameter P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] P_W = WIDTH'(P);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $fatal(1, "ffas: WIDTH must be a multiple of DIGIT");
  end
  if ((P >> WIDTH) != '0) begin : g_bad_p
    $fatal(1, "ffas: modulus P must be below 2**WIDTH");
  end

  typedef enum logic {IDLE, COMPUTE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  p_q, p_d;
  logic [WIDTH-1:0]  r1_q, r1_d;
  logic [WIDTH-1:0]  r2_q, r2_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              c1_q, c1_d;
  logic              c2_q, c2_d;
  logic              done_q, done_d;
  logic              take_t;
  logic [DIGIT:0]    sum1, sum2;

`ifdef FFAS_SUB_EN
  logic op_q, op_d;
`else
  logic unused_op;
  assign unused_op = op;
`endif

  // Per-digit slice arithmetic. Chain 1 is s=a+b (or d=a-b); chain 2 is
  // the corrected value t=s-P (or t=d+P). Bit DIGIT is the carry/borrow out.
  always_comb begin
    sum1 = '0;
    sum2 = '0;
`ifdef FFAS_SUB_EN
    if (op_q) begin
      sum1 = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, c1_q};
      sum2 = {1'b0, sum1[DIGIT-1:0]} + {1'b0, p_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c2_q};
    end else begin
      sum1 = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c1_q};
      sum2 = {1'b0, sum1[DIGIT-1:0]} - {1'b0, p_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, c2_q};
    end
`else
    sum1 = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c1_q};
    sum2 = {1'b0, sum1[DIGIT-1:0]} - {1'b0, p_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, c2_q};
`endif
  end

  // Next-state, operand latching, digit shifting and final result selection.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    done_d  = 1'b0;
    take_t  = 1'b0;
`ifdef FFAS_SUB_EN
    op_d    = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COMPUTE;
          a_d     = a;
          b_d     = b;
          p_d     = P_W;
          c1_d    = 1'b0;
          c2_d    = 1'b0;
          cnt_d   = '0;
`ifdef FFAS_SUB_EN
          op_d    = op;
`endif
        end
      end
      COMPUTE: begin
        // Operands and modulus shift down so the active slice is always at
        // bit 0; result slices enter from the top and settle LSB-aligned.
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        p_d   = p_q >> DIGIT;
        r1_d  = (r1_q >> DIGIT) | (WIDTH'(sum1[DIGIT-1:0]) << (WIDTH - DIGIT));
        r2_d  = (r2_q >> DIGIT) | (WIDTH'(sum2[DIGIT-1:0]) << (WIDTH - DIGIT));
        c1_d  = sum1[DIGIT];
        c2_d  = sum2[DIGIT];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
`ifdef FFAS_SUB_EN
          take_t = op_q ? sum1[DIGIT] : (sum1[DIGIT] | ~sum2[DIGIT]);
`else
          take_t = sum1[DIGIT] | ~sum2[DIGIT];
`endif
          out_d   = take_t ? r2_d : r1_d;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef FFAS_SUB_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      done_q  <= done_d;
`ifdef FFAS_SUB_EN
      op_q    <= op_d;
`endif
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign busy = (state_q == COMPUTE);

endmodule

// File: tb/tb_ffas.sv
// tb_ffas: directed checks of the ffas modular adder/subtractor, a 4-digit
// instance (DIGIT=64) and a single-digit instance (DIGIT=256).
module tb_ffas;

  localparam logic [255:0] P   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] PM1 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2E;
  localparam logic [255:0] PM2 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [255:0] a = '0;
  logic [255:0] b = '0;
  logic [255:0] out;
  logic         done;
  logic         busy;

  logic         start1 = 1'b0;
  logic         op1 = 1'b0;
  logic [255:0] a1 = '0;
  logic [255:0] b1 = '0;
  logic [255:0] out1;
  logic         done1;
  logic         busy1;

  int errors = 0;
  int checks = 0;

  ffas #(.WIDTH(256), .DIGIT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .out(out), .done(done), .busy(busy)
  );

  ffas #(.WIDTH(256), .DIGIT(256)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1),
    .out(out1), .done(done1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Present one request on the 4-digit instance; returns #1 after the accepting edge.
  task automatic issue(input logic o, input logic [255:0] x, input logic [255:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges after the accepting edge until done, and cycles with busy high.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 256'd1; b = 256'd2;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_vs_start: got %b want 0", busy); end
    checks++; if (busy1 !== 1'b0 || out1 !== '0) begin errors++; $display("FAIL reset_dut1: busy %b out %h want 0/0", busy1, out1); end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b want 0", busy); end
  endtask

  task automatic test_add_basic();
    int edges, bc;
    issue(1'b0, 256'd1, 256'd2);
    wait_done(edges, bc);
    checks++; if (edges != 4) begin errors++; $display("FAIL add_latency: got %0d want 4", edges); end
    checks++; if (bc != 4) begin errors++; $display("FAIL add_busy_cycles: got %0d want 4", bc); end
    checks++; if (out !== 256'd3) begin errors++; $display("FAIL add_1_2: got %h want 3", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_in_done_cycle: got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", done); end
    checks++; if (out !== 256'd3) begin errors++; $display("FAIL out_held: got %h want 3", out); end
  endtask

  task automatic test_add_wrap();
    logic [255:0] va [4];
    logic [255:0] vb [4];
    logic [255:0] ve [4];
    int edges, bc;
    va[0] = PM1;                 vb[0] = PM1;               ve[0] = PM2;
    va[1] = PM1;                 vb[1] = 256'd1;            ve[1] = '0;
    va[2] = 256'd1 << 255;       vb[2] = 256'd1 << 255;     ve[2] = 256'h1_000003D1;
    va[3] = PM1;                 vb[3] = '0;                ve[3] = PM1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, va[i], vb[i]);
      wait_done(edges, bc);
      checks++;
      if (edges != 4 || out !== ve[i]) begin
        errors++;
        $display("FAIL add_wrap[%0d]: got %h after %0d edges want %h after 4", i, out, edges, ve[i]);
      end
    end
  endtask

  task automatic test_op1();
    int edges, bc;
`ifdef FFAS_SUB_EN
    logic [255:0] va [3];
    logic [255:0] vb [3];
    logic [255:0] ve [3];
    va[0] = '0;      vb[0] = 256'd1; ve[0] = PM1;
    va[1] = 256'd5;  vb[1] = 256'd3; ve[1] = 256'd2;
    va[2] = 256'd3;  vb[2] = 256'd5; ve[2] = PM2;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, va[i], vb[i]);
      wait_done(edges, bc);
      checks++;
      if (edges != 4 || out !== ve[i]) begin
        errors++;
        $display("FAIL sub[%0d]: got %h after %0d edges want %h after 4", i, out, edges, ve[i]);
      end
    end
`else
    issue(1'b1, 256'd5, 256'd3);
    wait_done(edges, bc);
    checks++;
    if (edges != 4 || out !== 256'd8) begin
      errors++;
      $display("FAIL op_ignored: got %h after %0d edges want 8 after 4", out, edges);
    end
`endif
  endtask

  task automatic test_busy_ignore();
    int pulses = 0;
    int when = 0;
    logic [255:0] got = '0;
    issue(1'b0, 256'd10, 256'd20);
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 2) begin
        start = 1'b1; a = 256'd100; b = 256'd200;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin pulses++; when = e; got = out; end
    end
    start = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL busy_ignore_pulses: got %0d want 1", pulses); end
    checks++; if (when != 4) begin errors++; $display("FAIL busy_ignore_timing: got %0d want 4", when); end
    checks++; if (got !== 256'd30) begin errors++; $display("FAIL busy_ignore_result: got %h want 1e", got); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    int edges, bc;
    issue(1'b0, 256'd7, 256'd8);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out !== '0 || busy !== 1'b0) begin errors++; $display("FAIL abort_state: out %h busy %b want 0/0", out, busy); end
    for (int e = 0; e < 6; e++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
    checks++; if (out !== '0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: out %h busy %b want 0/0", out, busy); end
    issue(1'b0, 256'd40, 256'd2);
    wait_done(edges, bc);
    checks++;
    if (edges != 4 || out !== 256'd42) begin
      errors++;
      $display("FAIL after_abort: got %h after %0d edges want 2a after 4", out, edges);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start1 = 1'b1; a1 = PM1; b1 = PM1;
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL d256_accept: busy %b done %b want 1/0", busy1, done1); end
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk); #1;
    checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL d256_done: done %b busy %b want 1/0", done1, busy1); end
    checks++; if (out1 !== PM2) begin errors++; $display("FAIL d256_result: got %h want %h", out1, PM2); end
    @(negedge clk);
    start1 = 1'b1; a1 = 256'd1; b1 = 256'd2;
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL b2b_accept: busy %b done %b want 1/0", busy1, done1); end
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk); #1;
    checks++; if (done1 !== 1'b1 || out1 !== 256'd3) begin errors++; $display("FAIL b2b_result: done %b out %h want 1/3", done1, out1); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_wrap();
    test_op1();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ffas.md
FFAS -- requirements
Module: ffas

Interface
REQ-001 SHALL have parameter WIDTH, default 256, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 64, bits processed per compute cycle.
REQ-003 SHALL have parameter P, default 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F, field modulus.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset: synchronous and active-high.
REQ-006 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-007 SHALL have port op  input  1  0 = add, 1 = subtract; latched with start.
REQ-008 SHALL have port a  input  WIDTH  first operand; latched with start.
REQ-009 SHALL have port b  input  WIDTH  second operand; latched with start.
REQ-010 SHALL have port out  output  WIDTH  registered result, held until the next result.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking out valid.
REQ-012 SHALL have port busy  output  1  high while an operation is in flight.

Function
REQ-013 SHALL compute (a+b) mod P for op=0 and (a-b) mod P for op=1, for inputs a,b < P.
REQ-014 SHALL define N = WIDTH/DIGIT; WIDTH%DIGIT != 0 or P >= 2^WIDTH SHALL be a fatal elaboration error.
REQ-015 SHALL use FSM states IDLE and COMPUTE; IDLE->COMPUTE on start=1, COMPUTE->IDLE after digit N-1, rst->IDLE from any state.
REQ-016 SHALL latch a, b and op and clear carry/borrow and the digit counter on the edge that accepts start.
REQ-017 SHALL process one DIGIT-bit slice per COMPUTE edge, LSB slice first, with two parallel chains: add mode s=a+b and t=s-P; sub mode d=a-b and t=d+P.
REQ-018 SHALL select the result on the final COMPUTE edge: add mode t if (carry of s) or (no borrow of t), else s; sub mode t if final borrow of d, else d.
REQ-019 SHALL register out and assert done on the N-th edge after the start-accepting edge; busy high over exactly those N cycles.
REQ-020 SHALL assert done for exactly one cycle, with busy=0 in that same cycle.
REQ-021 SHALL accept a new start in the done cycle; the next result SHALL follow after N more edges.
REQ-022 SHALL ignore start while busy=1, with no effect on latched operands or timing.
REQ-023 SHALL leave out undefined-but-deterministic for inputs >= P; no error is flagged.

Reset
REQ-024 SHALL drive out=0, done=0, busy=0 and state=IDLE after any clock edge with rst=1.
REQ-025 SHALL abort an in-flight operation on reset, with no done pulse for it; rst has priority over start in the same cycle.

Configuration
REQ-026 SHALL compile in subtraction only when FFAS_SUB_EN is defined; the d/t subtract datapath and the op latch are present.
REQ-027 SHALL, without FFAS_SUB_EN, ignore op, always add, and produce identical add-mode results and latency.

Verification (WIDTH=256, DIGIT=64, default P, N=4)
REQ-028 SHALL check: op=0, a=1, b=2 -> out=3, done exactly 4 edges after start, busy high 4 cycles.
REQ-029 SHALL check: op=0, a=b=P-1 -> out=P-2 (...FFFFFC2D); and a=P-1, b=1 -> out=0.
REQ-030 SHALL check: op=1 (FFAS_SUB_EN), a=0, b=1 -> out=P-1 (...FFFFFC2E); a=5, b=3 -> out=2.
REQ-031 SHALL check: start pulsed again with different operands at cycle 2 of a busy operation -> ignored, first result unchanged, one done pulse.
REQ-032 SHALL check: rst=1 at COMPUTE cycle 2 -> no done, out=0, busy=0; the next start completes normally after 4 edges.
REQ-033 SHALL check: DIGIT=256 build, a=P-1, b=P-1 -> out=P-2 with done 1 edge after start; a start in the done cycle is accepted back-to-back.
